// File: rtl/inst_fifo_pkg.sv
// Shared constants, the entry layout and the register-address helper for the
// dual-issue instruction buffer.
package inst_fifo_pkg;

    localparam logic        RST_ENABLE = 1'b0;
    localparam logic [4:0]  ZERO5      = 5'd0;
    localparam logic [31:0] ZERO32     = 32'd0;

    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fifo_entry_t;

    function automatic logic [9:0] reg_addrs(input fifo_entry_t e);
        return {e.inst[RS_HI:RS_LO], e.inst[RT_HI:RT_LO]};
    endfunction

endpackage

// File: rtl/inst_fifo_if.sv
// Fetch/issue side bundle of the instruction buffer; master is the CPU front
// end driving pushes and consume counts, slave is the buffer itself.
interface inst_fifo_if #(
    parameter int PTR_W = 4
);
    logic             flush_i;
    logic             in_valid1_i;
    logic [63:0]      in_data1_i;
    logic             in_valid2_i;
    logic [63:0]      in_data2_i;
    logic             full_o;
    logic [1:0]       issue_cnt_i;
    logic             out_valid1_o;
    logic [63:0]      out_data1_o;
    logic             out_valid2_o;
    logic [63:0]      out_data2_o;
    logic [9:0]       raddr1_o;
    logic [9:0]       raddr2_o;
    logic [PTR_W:0]   count_o;

    modport master (
        output flush_i, in_valid1_i, in_data1_i, in_valid2_i, in_data2_i, issue_cnt_i,
        input  full_o, out_valid1_o, out_data1_o, out_valid2_o, out_data2_o,
               raddr1_o, raddr2_o, count_o
    );

    modport slave (
        input  flush_i, in_valid1_i, in_data1_i, in_valid2_i, in_data2_i, issue_cnt_i,
        output full_o, out_valid1_o, out_data1_o, out_valid2_o, out_data2_o,
               raddr1_o, raddr2_o, count_o
    );
endinterface

// File: rtl/inst_fifo_ptr.sv
// Head/tail/count bookkeeping; pointers carry a wrap bit so arithmetic is
// modulo 2*DEPTH and the low PTR_W bits index storage.
module inst_fifo_ptr
    import inst_fifo_pkg::*;
#(
    parameter int PTR_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     i_push_cnt,
    input  logic [1:0]     i_pop_cnt,
    input  logic           i_flush,
    output logic [PTR_W:0] o_head,
    output logic [PTR_W:0] o_tail,
    output logic [PTR_W:0] o_count
);

    logic [PTR_W:0] r_head, r_tail, r_count;
    logic [PTR_W:0] w_push, w_pop;

    assign w_push = (PTR_W+1)'(i_push_cnt);
    assign w_pop  = (PTR_W+1)'(i_pop_cnt);

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + w_pop;
            r_tail  <= r_tail + w_push;
            r_count <= r_count + w_push - w_pop;
        end
    end

    assign o_head  = r_head;
    assign o_tail  = r_tail;
    assign o_count = r_count;

endmodule

// File: rtl/inst_fifo.sv
// Dual-issue instruction buffer: up to two pushes from fetch per cycle, two
// oldest entries plus their rs/rt read addresses presented to issue.
module inst_fifo
    import inst_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    inst_fifo_if.slave bus
);

    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] CNT_TWO  = (PTR_W+1)'(2);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH - 2);

    fifo_entry_t    r_mem [DEPTH];

    logic [PTR_W:0]   w_head, w_tail, w_count, w_head1, w_tail1;
    logic [PTR_W-1:0] w_widx0, w_widx1;
    logic [1:0]       w_push_cnt, w_pop_cnt, w_issue, w_avail;
    logic             w_full, w_v1, w_v2;
    fifo_entry_t      w_e0, w_e1;

    inst_fifo_ptr #(.PTR_W(PTR_W)) u_ptr (
        .clk        (clk),
        .rst        (rst),
        .i_push_cnt (w_push_cnt),
        .i_pop_cnt  (w_pop_cnt),
        .i_flush    (bus.flush_i),
        .o_head     (w_head),
        .o_tail     (w_tail),
        .o_count    (w_count)
    );

    // Full leaves room for a whole pair, so a push never needs to be split.
    always_comb begin
        w_full     = (w_count > CNT_FULL);
        w_push_cnt = 2'd0;
        if (!w_full)
            w_push_cnt = {1'b0, bus.in_valid1_i} + {1'b0, bus.in_valid2_i};
        w_issue   = (bus.issue_cnt_i == 2'd3) ? 2'd2 : bus.issue_cnt_i;
        w_avail   = (w_count >= CNT_TWO) ? 2'd2 : w_count[1:0];
        w_pop_cnt = (w_issue < w_avail) ? w_issue : w_avail;
        w_head1   = w_head + CNT_ONE;
        w_tail1   = w_tail + CNT_ONE;
        w_widx0   = w_tail[PTR_W-1:0];
        w_widx1   = bus.in_valid1_i ? w_tail1[PTR_W-1:0] : w_tail[PTR_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!w_full && !bus.flush_i) begin
            if (bus.in_valid1_i) r_mem[w_widx0] <= bus.in_data1_i;
            if (bus.in_valid2_i) r_mem[w_widx1] <= bus.in_data2_i;
        end
    end

    always_comb begin
        w_v1 = (w_count >= CNT_ONE);
        w_v2 = (w_count >= CNT_TWO);
        w_e0 = r_mem[w_head[PTR_W-1:0]];
        w_e1 = r_mem[w_head1[PTR_W-1:0]];
    end

    assign bus.full_o       = w_full;
    assign bus.count_o      = w_count;
    assign bus.out_valid1_o = w_v1;
    assign bus.out_valid2_o = w_v2;
    assign bus.out_data1_o  = w_v1 ? w_e0 : {ZERO32, ZERO32};
    assign bus.out_data2_o  = w_v2 ? w_e1 : {ZERO32, ZERO32};
    assign bus.raddr1_o     = w_v1 ? reg_addrs(w_e0) : {ZERO5, ZERO5};
    assign bus.raddr2_o     = w_v2 ? reg_addrs(w_e1) : {ZERO5, ZERO5};

endmodule

// File: tb/tb_inst_fifo.sv
// Self-checking bench for inst_fifo against a queue-based reference model.
module tb_inst_fifo;

    localparam int DEPTH = 16;
    localparam int PTR_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    logic [63:0] q[$];

    inst_fifo_if #(.PTR_W(PTR_W)) bus();

    inst_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] exp_ra(input logic [63:0] e);
        return {e[25:21], e[20:16]};
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic idle();
        bus.flush_i     = 1'b0;
        bus.in_valid1_i = 1'b0;
        bus.in_valid2_i = 1'b0;
        bus.in_data1_i  = '0;
        bus.in_data2_i  = '0;
        bus.issue_cnt_i = 2'd0;
    endtask

    // One clock: the model applies the buffer's rules at the edge, then we
    // return on the falling edge where outputs are stable.
    task automatic cycle();
        int ic, pops;
        bit was_full;
        @(posedge clk);
        if (bus.flush_i) begin
            q.delete();
        end else begin
            was_full = (q.size() > DEPTH - 2);
            ic   = (bus.issue_cnt_i == 2'd3) ? 2 : int'(bus.issue_cnt_i);
            pops = (ic < q.size()) ? ic : q.size();
            repeat (pops) void'(q.pop_front());
            if (!was_full) begin
                if (bus.in_valid1_i) q.push_back(bus.in_data1_i);
                if (bus.in_valid2_i) q.push_back(bus.in_data2_i);
            end
        end
        @(negedge clk);
    endtask

    task automatic do_flush();
        idle();
        bus.flush_i = 1'b1;
        cycle();
        idle();
    endtask

    task automatic test_reset();
        logic [63:0] d;
        rst = 1'b0;
        repeat (3) begin
            bus.flush_i     = $urandom_range(0, 1);
            bus.in_valid1_i = $urandom_range(0, 1);
            bus.in_valid2_i = $urandom_range(0, 1);
            bus.in_data1_i  = rnd64();
            bus.in_data2_i  = rnd64();
            bus.issue_cnt_i = 2'($urandom_range(0, 3));
            @(negedge clk);
            total++;
            if ({bus.out_valid1_o, bus.out_valid2_o, bus.full_o, bus.count_o,
                 bus.out_data1_o, bus.out_data2_o, bus.raddr1_o, bus.raddr2_o} !== '0) begin
                bad++;
                $display("FAIL reset_outputs got v1=%b v2=%b full=%b cnt=%0d d1=%h d2=%h expected all zero",
                         bus.out_valid1_o, bus.out_valid2_o, bus.full_o, bus.count_o,
                         bus.out_data1_o, bus.out_data2_o);
            end
        end
        idle();
        rst = 1'b1;
        cycle();
        total++;
        if (bus.count_o !== 5'd0 || bus.out_valid1_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got cnt=%0d v1=%b expected 0/0", bus.count_o, bus.out_valid1_o);
        end
        d = 64'h0000_0100_0022_0000;
        bus.in_valid1_i = 1'b1;
        bus.in_data1_i  = d;
        #1;
        total++;
        if (bus.out_valid1_o !== 1'b0) begin
            bad++;
            $display("FAIL no_bypass got v1=%b expected 0", bus.out_valid1_o);
        end
        cycle();
        idle();
        total++;
        if (bus.out_valid1_o !== 1'b1 || bus.out_data1_o !== d || bus.count_o !== 5'd1) begin
            bad++;
            $display("FAIL first_push got v1=%b d1=%h cnt=%0d expected 1/%h/1",
                     bus.out_valid1_o, bus.out_data1_o, bus.count_o, d);
        end
    endtask

    task automatic test_dual();
        do_flush();
        bus.in_valid1_i = 1'b1; bus.in_data1_i = 64'h0000_1000_8C22_0004;
        bus.in_valid2_i = 1'b1; bus.in_data2_i = 64'h0000_1004_0085_1020;
        cycle();
        idle();
        total++;
        if (bus.out_valid1_o !== 1'b1 || bus.out_valid2_o !== 1'b1 || bus.count_o !== 5'd2 ||
            bus.raddr1_o !== {5'd1, 5'd2} || bus.raddr2_o !== {5'd4, 5'd5}) begin
            bad++;
            $display("FAIL dual_push got v=%b%b cnt=%0d ra1=%h ra2=%h expected 11/2/022/085",
                     bus.out_valid1_o, bus.out_valid2_o, bus.count_o, bus.raddr1_o, bus.raddr2_o);
        end
        total++;
        if (bus.out_data1_o !== q[0] || bus.out_data2_o !== q[1]) begin
            bad++;
            $display("FAIL dual_data got %h %h expected %h %h", bus.out_data1_o, bus.out_data2_o, q[0], q[1]);
        end
        bus.issue_cnt_i = 2'd2;
        cycle();
        idle();
        total++;
        if (bus.count_o !== 5'd0 || bus.out_valid1_o !== 1'b0 || bus.raddr1_o !== 10'd0) begin
            bad++;
            $display("FAIL dual_pop got cnt=%0d v1=%b ra1=%h expected 0/0/0", bus.count_o, bus.out_valid1_o, bus.raddr1_o);
        end
    endtask

    task automatic test_fill();
        do_flush();
        repeat (7) begin
            bus.in_valid1_i = 1'b1; bus.in_data1_i = rnd64();
            bus.in_valid2_i = 1'b1; bus.in_data2_i = rnd64();
            cycle();
        end
        total++;
        if (bus.count_o !== 5'd14 || bus.full_o !== 1'b0) begin
            bad++;
            $display("FAIL fill_14 got cnt=%0d full=%b expected 14/0", bus.count_o, bus.full_o);
        end
        bus.in_valid2_i = 1'b0;
        cycle();
        total++;
        if (bus.count_o !== 5'd15 || bus.full_o !== 1'b1) begin
            bad++;
            $display("FAIL fill_15 got cnt=%0d full=%b expected 15/1", bus.count_o, bus.full_o);
        end
        bus.in_valid2_i = 1'b1;
        cycle();
        total++;
        if (bus.count_o !== 5'd15 || q.size() != 15) begin
            bad++;
            $display("FAIL full_ignore got cnt=%0d expected 15", bus.count_o);
        end
        idle();
        bus.issue_cnt_i = 2'd1;
        cycle();
        total++;
        if (bus.count_o !== 5'd14 || bus.full_o !== 1'b0 || bus.out_data1_o !== q[0]) begin
            bad++;
            $display("FAIL full_pop got cnt=%0d full=%b d1=%h expected 14/0/%h",
                     bus.count_o, bus.full_o, bus.out_data1_o, q[0]);
        end
        idle();
        bus.in_valid1_i = 1'b1; bus.in_data1_i = rnd64();
        bus.in_valid2_i = 1'b1; bus.in_data2_i = rnd64();
        cycle();
        idle();
        total++;
        if (bus.count_o !== 5'd16 || bus.full_o !== 1'b1 || bus.out_data2_o !== q[1]) begin
            bad++;
            $display("FAIL fill_16 got cnt=%0d full=%b d2=%h expected 16/1/%h",
                     bus.count_o, bus.full_o, bus.out_data2_o, q[1]);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc;
        logic [31:0] next_pc;
        int errs;
        do_flush();
        exp_pc  = 32'h2000;
        next_pc = 32'h2000;
        bus.in_valid1_i = 1'b1; bus.in_data1_i = {next_pc, $urandom};
        next_pc += 4;
        cycle();
        errs = 0;
        for (int i = 0; i < 40; i++) begin
            bus.in_valid1_i = 1'b1; bus.in_data1_i = {next_pc, $urandom};
            bus.issue_cnt_i = 2'd1;
            next_pc += 4;
            if (bus.out_data1_o[63:32] !== exp_pc || bus.count_o !== 5'd1 ||
                bus.out_data1_o !== q[0]) begin
                errs++;
                if (errs == 1)
                    $display("FAIL wrap_step%0d got pc=%h cnt=%0d expected pc=%h cnt=1",
                             i, bus.out_data1_o[63:32], bus.count_o, exp_pc);
            end
            cycle();
            exp_pc += 4;
        end
        idle();
        total++;
        if (errs != 0) bad++;
        total++;
        if (bus.out_data1_o[63:32] !== exp_pc) begin
            bad++;
            $display("FAIL wrap_final got pc=%h expected %h", bus.out_data1_o[63:32], exp_pc);
        end
    endtask

    task automatic test_simul();
        logic [63:0] nh0, nh1;
        do_flush();
        for (int i = 0; i < 3; i++) begin
            bus.in_valid1_i = 1'b1; bus.in_data1_i = rnd64();
            bus.in_valid2_i = (i < 2); bus.in_data2_i = rnd64();
            cycle();
        end
        total++;
        if (bus.count_o !== 5'd5) begin
            bad++;
            $display("FAIL simul_pre got cnt=%0d expected 5", bus.count_o);
        end
        nh0 = q[1];
        nh1 = q[2];
        bus.in_valid1_i = 1'b1; bus.in_data1_i = rnd64();
        bus.in_valid2_i = 1'b1; bus.in_data2_i = rnd64();
        bus.issue_cnt_i = 2'd1;
        cycle();
        idle();
        total++;
        if (bus.count_o !== 5'd6 || bus.out_data1_o !== nh0 || bus.out_data2_o !== nh1) begin
            bad++;
            $display("FAIL simul got cnt=%0d d1=%h d2=%h expected 6/%h/%h",
                     bus.count_o, bus.out_data1_o, bus.out_data2_o, nh0, nh1);
        end
    endtask

    task automatic test_flush_overpop();
        bus.flush_i = 1'b1;
        bus.in_valid1_i = 1'b1; bus.in_data1_i = rnd64();
        bus.in_valid2_i = 1'b1; bus.in_data2_i = rnd64();
        bus.issue_cnt_i = 2'd1;
        cycle();
        idle();
        total++;
        if (bus.count_o !== 5'd0 || bus.out_valid1_o !== 1'b0 || bus.out_data1_o !== 64'd0) begin
            bad++;
            $display("FAIL flush got cnt=%0d v1=%b d1=%h expected 0/0/0", bus.count_o, bus.out_valid1_o, bus.out_data1_o);
        end
        bus.in_valid2_i = 1'b1; bus.in_data2_i = rnd64();
        cycle();
        idle();
        total++;
        if (bus.count_o !== 5'd1 || bus.out_data1_o !== q[0] || bus.out_valid2_o !== 1'b0) begin
            bad++;
            $display("FAIL slot2_only got cnt=%0d d1=%h v2=%b expected 1/%h/0",
                     bus.count_o, bus.out_data1_o, bus.out_valid2_o, q[0]);
        end
        bus.issue_cnt_i = 2'd2;
        cycle();
        total++;
        if (bus.count_o !== 5'd0 || bus.out_valid1_o !== 1'b0) begin
            bad++;
            $display("FAIL overpop got cnt=%0d v1=%b expected 0/0", bus.count_o, bus.out_valid1_o);
        end
        bus.issue_cnt_i = 2'd3;
        cycle();
        idle();
        total++;
        if (bus.count_o !== 5'd0) begin
            bad++;
            $display("FAIL empty_pop got cnt=%0d expected 0", bus.count_o);
        end
    endtask

    task automatic test_random();
        int errs;
        logic [63:0] e1, e2;
        errs = 0;
        do_flush();
        for (int i = 0; i < 400; i++) begin
            bus.flush_i     = ($urandom_range(0, 39) == 0);
            bus.in_valid1_i = ($urandom_range(0, 9) < 6);
            bus.in_valid2_i = ($urandom_range(0, 9) < 5);
            bus.in_data1_i  = rnd64();
            bus.in_data2_i  = rnd64();
            bus.issue_cnt_i = 2'($urandom_range(0, 3));
            cycle();
            e1 = (q.size() >= 1) ? q[0] : 64'd0;
            e2 = (q.size() >= 2) ? q[1] : 64'd0;
            total++;
            if (bus.count_o !== 5'(q.size()) || bus.full_o !== (q.size() > DEPTH - 2) ||
                bus.out_valid1_o !== (q.size() >= 1) || bus.out_valid2_o !== (q.size() >= 2) ||
                bus.out_data1_o !== e1 || bus.out_data2_o !== e2 ||
                bus.raddr1_o !== exp_ra(e1) || bus.raddr2_o !== exp_ra(e2)) begin
                bad++;
                errs++;
                if (errs <= 5)
                    $display("FAIL random_cyc%0d got cnt=%0d full=%b d1=%h d2=%h expected cnt=%0d d1=%h d2=%h",
                             i, bus.count_o, bus.full_o, bus.out_data1_o, bus.out_data2_o, q.size(), e1, e2);
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        do_flush();
        bus.in_valid1_i = 1'b1; bus.in_data1_i = rnd64();
        bus.in_valid2_i = 1'b1; bus.in_data2_i = rnd64();
        cycle();
        idle();
        #2;
        rst = 1'b0;
        #1;
        q.delete();
        total++;
        if (bus.count_o !== 5'd0 || bus.out_valid1_o !== 1'b0 || bus.out_data1_o !== 64'd0) begin
            bad++;
            $display("FAIL async_reset got cnt=%0d v1=%b d1=%h expected 0/0/0",
                     bus.count_o, bus.out_valid1_o, bus.out_data1_o);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        idle();
        test_reset();
        test_dual();
        test_fill();
        test_wrap();
        test_simul();
        test_flush_overpop();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
